// File: rtl/picosoc_wb_master_if.sv
// Wishbone classic master-side signal bundle for the picorv32 bridge.
// Signal names keep the master's point of view (_o driven by master, _i by slave).
interface picosoc_wb_master_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/picosoc_wb_master.sv
// picorv32 valid/ready to Wishbone classic single-transfer bridge with an
// ack watchdog that returns ERR_DATA and raises a sticky bus error flag.
module picosoc_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       mem_valid,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    picosoc_wb_master_if.master        wb,
    input  logic                       err_clr_i,
    output logic                       bus_err_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            bus_err_q, bus_err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        ready_d   = ready_q;
        rdata_d   = rdata_q;
        // A set later in this block overrides the clear.
        bus_err_d = err_clr_i ? 1'b0 : bus_err_q;

        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    adr_d   = mem_addr;
                    dat_d   = mem_wdata;
                    sel_d   = (mem_wstrb != 4'h0) ? mem_wstrb : 4'hF;
                    we_d    = (mem_wstrb != 4'h0);
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                if (wb.wb_err_i || (!wb.wb_ack_i && cnt_q == CntMax)) begin
                    rdata_d   = ERR_DATA;
                    bus_err_d = 1'b1;
                    cyc_d     = 1'b0;
                    ready_d   = 1'b1;
                    state_d   = StResp;
                end else if (wb.wb_ack_i) begin
                    if (!we_q) begin
                        rdata_d = wb.wb_dat_i;
                    end
                    cyc_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                ready_d = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_picosoc_wb_master.sv
// Randomized bench for picosoc_wb_master: Wishbone RAM slave with programmable
// response timing, word-level scoreboard and bus protocol monitor.
module tb_picosoc_wb_master;

    localparam int unsigned Timeout = 16;
    localparam logic [31:0] ErrWord = 32'hDEADBEEF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err_clr_i;
    logic        bus_err_o;

    picosoc_wb_master_if wb_bus ();

    picosoc_wb_master #(
        .TIMEOUT_CYCLES (Timeout),
        .ERR_DATA       (ErrWord)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .wb        (wb_bus),
        .err_clr_i (err_clr_i),
        .bus_err_o (bus_err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_issued = 0;
    int n_done   = 0;

    // Slave behaviour: respond on the ack_at-th negedge of the open cycle.
    int          ack_at = 2;
    bit          s_ack  = 1'b1;
    bit          s_err  = 1'b0;
    logic [3:0]  last_sel;
    logic        last_we;

    // Monitor results.
    int ready_pulses = 0;
    int cyc_starts   = 0;
    int last_cyc_len = 0;
    int viol         = 0;

    logic [31:0] exp_mem [64];

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h12345678;
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wishbone RAM slave, driven on negedges.
    initial begin : slave
        logic [31:0] ram [64];
        int          wcnt = 0;
        bit          responded = 1'b0;
        int          idx;
        for (int i = 0; i < 64; i++) ram[i] = init_word(i);
        wb_bus.wb_ack_i = 1'b0;
        wb_bus.wb_err_i = 1'b0;
        wb_bus.wb_dat_i = 32'h0;
        forever begin
            @(negedge wb_clk_i);
            wb_bus.wb_ack_i = 1'b0;
            wb_bus.wb_err_i = 1'b0;
            wb_bus.wb_dat_i = $urandom;
            if (wb_bus.wb_cyc_o && !responded) begin
                wcnt++;
                if (wcnt == ack_at) begin
                    responded = 1'b1;
                    idx = int'(wb_bus.wb_adr_o[7:2]);
                    last_sel = wb_bus.wb_sel_o;
                    last_we  = wb_bus.wb_we_o;
                    wb_bus.wb_ack_i = s_ack;
                    wb_bus.wb_err_i = s_err;
                    if (wb_bus.wb_we_o && s_ack && !s_err) begin
                        ram[idx] = merge(ram[idx], wb_bus.wb_dat_o, wb_bus.wb_sel_o);
                    end
                    wb_bus.wb_dat_i = ram[idx];
                end
            end else if (!wb_bus.wb_cyc_o) begin
                wcnt = 0;
                responded = 1'b0;
            end
        end
    end

    // Protocol monitor: pulse counts, cycle length and latched-field stability.
    initial begin : monitor
        logic        p_cyc = 1'b0;
        logic [31:0] p_adr, p_dat;
        logic [3:0]  p_sel;
        logic        p_we;
        int          run = 0;
        forever begin
            @(negedge wb_clk_i);
            if (mem_ready) ready_pulses++;
            if (wb_bus.wb_stb_o !== wb_bus.wb_cyc_o) viol++;
            if (wb_bus.wb_cyc_o && !p_cyc) cyc_starts++;
            if (wb_bus.wb_cyc_o && p_cyc && ({p_adr, p_dat, p_sel, p_we} !==
                {wb_bus.wb_adr_o, wb_bus.wb_dat_o, wb_bus.wb_sel_o, wb_bus.wb_we_o})) viol++;
            if (wb_bus.wb_cyc_o) begin
                run++;
            end else if (run > 0) begin
                last_cyc_len = run;
                run = 0;
            end
            p_cyc = wb_bus.wb_cyc_o;
            p_adr = wb_bus.wb_adr_o;
            p_dat = wb_bus.wb_dat_o;
            p_sel = wb_bus.wb_sel_o;
            p_we  = wb_bus.wb_we_o;
        end
    end

    // Called at a negedge; returns at the negedge after the mem_ready pulse.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int budget, output logic [31:0] rd, output int lat);
        bit done = 1'b0;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid = 1'b1;
        n_issued++;
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge wb_clk_i);
            lat++;
            if (mem_ready) done = 1'b1;
        end
        rd = mem_rdata;
        mem_valid = 1'b0;
        if (!done) check("req_completes", 32'h0, 32'h1);
        else n_done++;
        @(negedge wb_clk_i);
        check("ready_one_cycle", 32'(mem_ready), 32'h0);
    endtask

    task automatic pulse_clr();
        err_clr_i = 1'b1;
        @(negedge wb_clk_i);
        err_clr_i = 1'b0;
        check("bus_err_cleared", 32'(bus_err_o), 32'h0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        logic [31:0] rd;
        logic [31:0] last_rdata;
        int          lat;
        int          idx;
        int          d;
        logic [31:0] a, wd;
        logic [3:0]  s;

        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        wb_rst_i  = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        err_clr_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);

        check("rst_cyc", 32'(wb_bus.wb_cyc_o), 32'h0);
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_bus_err", 32'(bus_err_o), 32'h0);
        check("rst_sel", 32'(wb_bus.wb_sel_o), 32'h0);
        check("rst_we", 32'(wb_bus.wb_we_o), 32'h0);
        check("rst_adr", wb_bus.wb_adr_o, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Registered-ack read.
        ack_at = 2; s_ack = 1'b1; s_err = 1'b0;
        do_req(32'h40, 32'h0, 4'h0, 40, rd, lat);
        check("rd40_data", rd, 32'h12345678);
        check("rd40_latency", 32'(lat), 32'd3);
        check("rd40_sel", 32'(last_sel), 32'hF);
        check("rd40_we", 32'(last_we), 32'h0);

        // Partial write, rdata must not move, then read back.
        do_req(32'h44, 32'hAABBCCDD, 4'b0110, 40, rd, lat);
        exp_mem[17] = merge(exp_mem[17], 32'hAABBCCDD, 4'b0110);
        check("wr44_rdata_kept", rd, 32'h12345678);
        check("wr44_we", 32'(last_we), 32'h1);
        check("wr44_sel", 32'(last_sel), 32'h6);
        do_req(32'h44, 32'h0, 4'h0, 40, rd, lat);
        check("rd44_data", rd, exp_mem[17]);

        // Silent slave: watchdog fires after TIMEOUT cycles of cyc.
        ack_at = 1000;
        do_req(32'h80, 32'h0, 4'h0, 40, rd, lat);
        check("to_rdata", rd, ErrWord);
        check("to_cyc_len", 32'(last_cyc_len), Timeout);
        check("to_bus_err", 32'(bus_err_o), 32'h1);
        ack_at = 2;
        do_req(32'h40, 32'h0, 4'h0, 40, rd, lat);
        check("err_sticky", 32'(bus_err_o), 32'h1);
        check("sticky_rd_data", rd, 32'h12345678);
        pulse_clr();

        // ack and err together: err wins.
        s_err = 1'b1;
        do_req(32'h40, 32'h0, 4'h0, 40, rd, lat);
        check("ackerr_rdata", rd, ErrWord);
        check("ackerr_bus_err", 32'(bus_err_o), 32'h1);
        s_err = 1'b0;
        pulse_clr();

        // ack on the last allowed cycle is a normal completion.
        ack_at = Timeout;
        do_req(32'h40, 32'h0, 4'h0, 40, rd, lat);
        check("lastack_rdata", rd, 32'h12345678);
        check("lastack_bus_err", 32'(bus_err_o), 32'h0);
        check("lastack_cyc_len", 32'(last_cyc_len), Timeout);

        // err_clr_i in the same cycle as an err: set wins.
        ack_at = 2; s_err = 1'b1;
        mem_addr = 32'h40; mem_wstrb = 4'h0; mem_valid = 1'b1;
        n_issued++;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        err_clr_i = 1'b1;
        @(negedge wb_clk_i);
        err_clr_i = 1'b0;
        mem_valid = 1'b0;
        check("clrset_ready", 32'(mem_ready), 32'h1);
        if (mem_ready) n_done++;
        check("clrset_bus_err", 32'(bus_err_o), 32'h1);
        s_err = 1'b0;
        @(negedge wb_clk_i);
        pulse_clr();

        // Reset in the middle of an open cycle.
        ack_at = 1000;
        mem_addr = 32'h48; mem_wstrb = 4'h0; mem_valid = 1'b1;
        n_issued++;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        check("midrst_cyc", 32'(wb_bus.wb_cyc_o), 32'h0);
        check("midrst_ready", 32'(mem_ready), 32'h0);
        mem_valid = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        ack_at = 2;
        do_req(32'h48, 32'h0, 4'h0, 40, rd, lat);
        check("postrst_rd", rd, exp_mem[18]);
        last_rdata = rd;

        // Random back-to-back traffic against the scoreboard.
        for (int n = 0; n < 100; n++) begin
            idx = int'($urandom_range(0, 63));
            a   = 32'(idx) << 2;
            wd  = $urandom;
            s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            d   = int'($urandom_range(0, 5));
            ack_at = 2 + d;
            do_req(a, wd, s, 40, rd, lat);
            if (s == 4'h0) begin
                check("rand_rd", rd, exp_mem[idx]);
                last_rdata = rd;
            end else begin
                exp_mem[idx] = merge(exp_mem[idx], wd, s);
                check("rand_wr_rdata", rd, last_rdata);
            end
            check("rand_latency", 32'(lat), 32'(3 + d));
        end

        @(negedge wb_clk_i);
        check("bus_err_final", 32'(bus_err_o), 32'h0);
        check("ready_pulses", 32'(ready_pulses), 32'(n_done));
        check("cyc_starts", 32'(cyc_starts), 32'(n_issued));
        check("protocol_viol", 32'(viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
